// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and counter-width helper for the serializer
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} piso_state_t;
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out stage with a one-word holding slot
// and first/last frame markers; consecutive words leave with no idle bit.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    piso_state_t      r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_hold;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hold_valid;
    logic             r_ready;
    logic             w_accept;
    logic             w_end;
    logic             w_free;
    logic             w_hold_nxt;
    logic [WIDTH-1:0] w_shifted;
    assign w_accept   = in_valid & r_ready;
    assign w_end      = (r_state == SHIFT) & (r_cnt == LAST) & shift_en;
    assign w_free     = (r_state == IDLE) | (w_end & ~r_hold_valid);
    // in_ready is kept as a register so reset forces it low without a path from rst
    assign w_hold_nxt = (w_accept & ~w_free) | (r_hold_valid & ~w_end);
    assign w_shifted  = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sreg       <= '0;
            r_hold       <= '0;
            r_cnt        <= '0;
            r_hold_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_ready <= ~w_hold_nxt;
            if (w_accept && w_free) begin
                r_sreg  <= in_data;
                r_cnt   <= '0;
                r_state <= SHIFT;
            end else begin
                if (w_accept) begin
                    r_hold       <= in_data;
                    r_hold_valid <= 1'b1;
                end
                if (r_state == SHIFT && shift_en) begin
                    if (r_cnt != LAST) begin
                        r_sreg <= w_shifted;
                        r_cnt  <= r_cnt + 1'b1;
                    end else if (r_hold_valid) begin
                        r_sreg       <= r_hold;
                        r_hold_valid <= 1'b0;
                        r_cnt        <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            end
        end
    end
    assign in_ready  = r_ready;
    assign ser_out   = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
    assign ser_valid = (r_state == SHIFT);
    assign ser_first = ser_valid & (r_cnt == '0);
    assign ser_last  = ser_valid & (r_cnt == LAST);
    assign busy      = ser_valid | r_hold_valid;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: MSB- and LSB-first serializers on shared stimulus, checked
// every cycle against a word/position/queue model plus literal bit patterns.
module tb_piso_serializer;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic shift_en = 1'b1;
    logic [W-1:0] in_data = '0;
    logic m_rdy, m_out, m_val, m_first, m_last, m_busy;
    logic l_rdy, l_out, l_val, l_first, l_last, l_busy;
    int total = 0;
    int bad = 0;
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_rdy), .in_data(in_data),
        .shift_en(shift_en), .ser_out(m_out), .ser_valid(m_val), .ser_first(m_first),
        .ser_last(m_last), .busy(m_busy));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_rdy), .in_data(in_data),
        .shift_en(shift_en), .ser_out(l_out), .ser_valid(l_val), .ser_first(l_first),
        .ser_last(l_last), .busy(l_busy));
    always #5 clk = ~clk;
    // model: current word, bit position within it, and a one-deep pending queue
    logic [W-1:0] mw = '0;
    int mp = 0;
    bit mact = 0;
    bit mrdy = 0;
    bit acc, fin, free;
    logic [W-1:0] pend[$];
    bit q_m[$];
    bit q_l[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mact = 0; mp = 0; mw = '0; mrdy = 0; pend.delete();
        end else begin
            acc  = in_valid && mrdy;
            fin  = mact && mp == W - 1 && shift_en;
            free = !mact || (fin && pend.size() == 0);
            if (acc && free) begin
                mw = in_data; mp = 0; mact = 1;
            end else begin
                if (mact && shift_en) begin
                    if (mp < W - 1) mp++;
                    else if (pend.size() > 0) begin mw = pend.pop_front(); mp = 0; end
                    else mact = 0;
                end
                if (acc) pend.push_back(in_data);
            end
            mrdy = pend.size() == 0;
        end
    end
    task automatic cmp(input string t, input logic rdy, o, v, f, l, b, input bit msb);
        chk({t, "_ready"}, 32'(rdy), 32'(mrdy));
        chk({t, "_valid"}, 32'(v), 32'(mact));
        chk({t, "_first"}, 32'(f), 32'(mact && mp == 0));
        chk({t, "_last"}, 32'(l), 32'(mact && mp == W - 1));
        chk({t, "_busy"}, 32'(b), 32'(mact || pend.size() > 0));
        if (mact) chk({t, "_out"}, 32'(o), 32'(msb ? mw[W-1-mp] : mw[mp]));
    endtask
    always @(negedge clk) begin
        cmp("msb", m_rdy, m_out, m_val, m_first, m_last, m_busy, 1'b1);
        cmp("lsb", l_rdy, l_out, l_val, l_first, l_last, l_busy, 1'b0);
        if (m_val) q_m.push_back(m_out);
        if (l_val) q_l.push_back(l_out);
    end
    function automatic logic [31:0] packq(input bit lsb, input int start, input int n, input int step);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) begin
            if (start + i * step >= (lsb ? q_l.size() : q_m.size())) return 32'hFFFF_FFFF;
            v = {v[30:0], lsb ? q_l[start+i*step] : q_m[start+i*step]};
        end
        return v;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [W-1:0] d);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = m_rdy;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask
    task automatic clearq();
        q_m.delete();
        q_l.delete();
    endtask
    initial begin
        tick();
        tick();
        chk("rst_ready", 32'(m_rdy), 32'd0);
        chk("rst_valid", 32'(m_val), 32'd0);
        chk("rst_out", 32'({m_out, l_out}), 32'd0);
        rst = 1'b0;
        chk("rel_ready_pre", 32'(m_rdy), 32'd0);
        tick();
        chk("rel_ready", 32'(m_rdy), 32'd1);
        chk("rel_valid", 32'(m_val), 32'd0);
        // single word
        clearq();
        send(8'hAA);
        chk("aa_first", 32'(m_first), 32'd1);
        repeat (10) tick();
        chk("aa_msb", packq(0, 0, 8, 1), 32'hAA);
        chk("aa_lsb", packq(1, 0, 8, 1), 32'h55);
        chk("aa_len", 32'(q_m.size()), 32'd8);
        chk("aa_idle", 32'({m_val, m_busy}), 32'd0);
        // back-to-back
        clearq();
        send(8'hCC);
        send(8'hF0);
        chk("b2b_ready_low", 32'(m_rdy), 32'd0);
        chk("b2b_busy", 32'(m_busy), 32'd1);
        repeat (18) tick();
        chk("b2b_bits", packq(0, 0, 16, 1), 32'hCCF0);
        chk("b2b_len", 32'(q_m.size()), 32'd16);
        // paced shifting, shift_en every 4th cycle
        clearq();
        fork
            for (int k = 0; k < 110; k++) begin
                shift_en = (k % 4 == 0);
                tick();
            end
            begin
                send(8'h81);
                send(8'h7E);
                tick();
                chk("pace_refuse", 32'(m_rdy), 32'd0);
                send(8'h3C);
            end
        join
        shift_en = 1'b1;
        tick();
        chk("pace_w1", packq(0, 0, 8, 4), 32'h81);
        chk("pace_w1_tail", packq(0, 3, 8, 4), 32'h81);
        chk("pace_w2", packq(0, 32, 8, 4), 32'h7E);
        chk("pace_w3", packq(0, 64, 8, 4), 32'h3C);
        chk("pace_len", 32'(q_m.size()), 32'd96);
        // accept landing exactly on the last bit
        clearq();
        send(8'hA5);
        for (int i = 0; i < 20 && !m_last; i++) tick();
        chk("lb_seen", 32'(m_last), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h0F;
        tick();
        in_valid = 1'b0;
        chk("lb_first", 32'({m_val, m_first, m_out}), 32'b110);
        repeat (10) tick();
        chk("lb_bits", packq(0, 0, 16, 1), 32'hA50F);
        // LSB-first word cut by an asynchronous reset mid-word
        clearq();
        send(8'hB4);
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outs", 32'({m_rdy, m_out, m_val, m_first, m_last, m_busy,
                                 l_rdy, l_out, l_val, l_first, l_last, l_busy}), 32'd0);
        chk("mid_rst_bits", packq(1, 0, 3, 1), 32'b001);
        chk("mid_rst_len", 32'(q_l.size()), 32'd3);
        tick();
        rst = 1'b0;
        tick();
        clearq();
        send(8'h01);
        repeat (10) tick();
        chk("post_rst_lsb", packq(1, 0, 8, 1), 32'h80);
        chk("post_rst_msb", packq(0, 0, 8, 1), 32'h01);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = W'($urandom);
            shift_en = $urandom_range(0, 9) < 7;
            tick();
        end
        in_valid = 1'b0;
        shift_en = 1'b1;
        repeat (20) tick();
        chk("final_idle", 32'({m_busy, l_busy}), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
